// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register and applies redirects, stalls and halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int unsigned PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt,
  input  logic            Stall,
  input  logic [31:0]     InstrIn,
  output logic [PC_W-1:0] ImemAddr,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Halted,
  output logic            Fault,
  output logic [15:0]     RedirCnt,
  output logic [15:0]     StallCnt
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StHalted = 2'd1;
  localparam logic [1:0] StFault  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            redir_evt, stall_evt;

  logic [PC_W-1:0] target;
  logic            target_misaligned;

  // Target bits above the PC width are dropped without any indication.
  assign target            = BrPC[PC_W-1:0];
  assign target_misaligned = (BrPC[1:0] != 2'b00);

  logic unused_brpc;
  assign unused_brpc = ^BrPC[31:PC_W];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    redir_evt    = 1'b0;
    stall_evt    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (PcSel) begin
          // Any redirect squashes the wrong-path instruction, even under a stall.
          redir_evt    = 1'b1;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          if (Halt) begin
            pc_d    = target;
            state_d = StHalted;
          end else if (target_misaligned) begin
            state_d = StFault;
          end else begin
            pc_d = target;
          end
        end else if (Stall) begin
          stall_evt = 1'b1;
        end else begin
          pc_d         = pc_q + PC_W'(4);
          ifid_pc_d    = pc_q;
          ifid_instr_d = InstrIn;
          ifid_valid_d = 1'b1;
        end
      end
      StHalted, StFault: begin
        ifid_pc_d    = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
      end
      default: begin
        // Unused encoding: park in the fault state rather than fetch garbage.
        state_d      = StFault;
        ifid_pc_d    = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign IfId_PC    = ifid_pc_q;
  assign IfId_Instr = ifid_instr_q;
  assign IfId_Valid = ifid_valid_q;
  assign Halted     = (state_q == StHalted);
  assign Fault      = (state_q == StFault);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redir_cnt_q, stall_cnt_q;

  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redir_evt && (redir_cnt_q != 16'hFFFF)) begin
        redir_cnt_q <= redir_cnt_q + 16'd1;
      end
      if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign RedirCnt = redir_cnt_q;
  assign StallCnt = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = redir_evt ^ stall_evt;

  assign RedirCnt = '0;
  assign StallCnt = '0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline: owns the program counter and the IF/ID pipeline register. It consumes the redirect produced by the branch unit in EX (`PcSel`/`BrPC`), applies hazard-unit stalls, flushes the wrong-path instruction on a taken redirect, and latches the halt condition. It sits between the instruction memory (combinational read) and the decode stage.

## Interface
- `PC_W`, 9: program counter width in bits; byte address into instruction memory.
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `PcSel` input 1: redirect request from EX (taken branch/jump or halt loop).
- `BrPC` input 32: redirect target; only bits `[PC_W-1:0]` used.
- `Halt` input 1: EX-stage halt indication, qualified by `PcSel`.
- `Stall` input 1: hazard-unit stall; freeze PC and IF/ID.
- `InstrIn` input 32: instruction memory read data for `ImemAddr`, same cycle.
- `ImemAddr` output PC_W: current PC, drives instruction memory.
- `IfId_PC` output PC_W: PC of instruction held in IF/ID.
- `IfId_Instr` output 32: instruction held in IF/ID.
- `IfId_Valid` output 1: IF/ID holds a real instruction.
- `Halted` output 1: fetch permanently stopped by halt.
- `Fault` output 1: fetch stopped by misaligned redirect target.
- `RedirCnt`, `StallCnt` output 16 each: performance counters (see Configuration).

## Operation
- State machine, 2-bit: RUN, HALTED, FAULT. Reset → RUN.
- RUN, next PC priority (highest first):
  1. `PcSel && Halt`: PC ← `BrPC[PC_W-1:0]`, state → HALTED.
  2. `PcSel && BrPC[1:0] != 0`: PC holds, state → FAULT.
  3. `PcSel`: PC ← `BrPC[PC_W-1:0]`.
  4. `Stall`: PC holds.
  5. otherwise PC ← PC + 4, modulo 2^PC_W (wraps from 2^PC_W−4 to 0, no flag).
- IF/ID in RUN:
  - any `PcSel` (cases 1-3): flush → `IfId_Valid`=0, `IfId_Instr`=0, `IfId_PC`=0. Redirect overrides `Stall`.
  - `Stall` without `PcSel`: all IF/ID fields hold.
  - otherwise: load `IfId_PC`←PC, `IfId_Instr`←`InstrIn`, `IfId_Valid`←1.
- HALTED / FAULT: PC holds, IF/ID held flushed (valid 0), all inputs ignored; exit only via reset. `Halted`=1 in HALTED, `Fault`=1 in FAULT, both registered state decodes.
- `ImemAddr` = PC register, combinational.
- Target bits above `PC_W-1` ignored silently.

## Timing
- Reset (`reset`=0 at a rising edge): PC=0, `IfId_PC`=0, `IfId_Instr`=0, `IfId_Valid`=0, `Halted`=0, `Fault`=0, counters 0, state RUN. Reset mid-halt/fault returns to RUN the next edge.
- First cycle after reset release: `ImemAddr`=0; instruction at 0 appears in IF/ID one edge later with `IfId_Valid`=1.
- Fetch-to-IF/ID latency: 1 cycle. Redirect latency: target on `ImemAddr` the cycle after `PcSel` sampled; target instruction in IF/ID one cycle later; exactly one bubble in IF/ID.
- `PcSel` and `Stall` sampled only on rising edges; pulses of 1 cycle suffice. `PcSel` held multiple cycles re-redirects each cycle.
- Stall held N cycles: PC and IF/ID frozen N cycles, fetch resumes with PC+4 on the first unstalled edge.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `RedirCnt` increments on each edge with `PcSel`=1 in RUN (including halt/fault entry); `StallCnt` increments on each edge with `Stall`=1 and `PcSel`=0 in RUN. Both 16-bit, saturate at 0xFFFF, cleared by reset.
- Not defined: counter registers absent, `RedirCnt` and `StallCnt` tied to 0.

## Test plan
- Reset then free-run, `InstrIn`=0x00000013+PC: after 3 edges `ImemAddr`=0x00C, `IfId_PC`=0x008, `IfId_Valid`=1.
- PC at 0x010, `PcSel`=1, `BrPC`=0x040, `Stall`=1 same cycle: next cycle `ImemAddr`=0x040, `IfId_Valid`=0; following cycle `IfId_PC`=0x040, valid 1.
- `Stall`=1 for 3 cycles at PC 0x020: `ImemAddr` and `IfId_*` constant for 3 cycles, then `ImemAddr`=0x024; with `FETCH_PERF_CNT_EN`, `StallCnt`=3.
- PC_W=9, PC=0x1FC, no stall: next `ImemAddr`=0x000, no fault.
- `PcSel`=1, `Halt`=1, `BrPC`=0x030: `Halted`=1 next cycle, `ImemAddr`=0x030 thereafter, `IfId_Valid`=0 despite further `PcSel`/`BrPC` changes; `reset`=0 one edge → PC=0, `Halted`=0.
- `PcSel`=1, `BrPC`=0x042: `Fault`=1 next cycle, `ImemAddr` unchanged, `IfId_Valid`=0 until reset.
